pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stall with timeout fault, branch/jump flush, load-use bubble.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Load_EX,
   input  logic [4:0]  rt_EX,
   input  logic [4:0]  rs_ID,
   input  logic [4:0]  rt_ID,
   input  logic        UsesRt_ID,
   input  logic        BranchTaken_EX,
   input  logic        Jump_ID,
   input  logic        MemReq_MEM,
   input  logic        MemReady,
   output logic        hold_PC,
   output logic        hold_IFID,
   output logic        hold_IDEX,
   output logic        hold_EXMEM,
   output logic        flush_IFID,
   output logic        flush_IDEX,
   output logic [1:0]  ctrl_state,
   output logic        mem_fault,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_events
);

   localparam int unsigned CNT_W = 16;
   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_MEM_WAIT = 2'd1;
   localparam logic [1:0] ST_FAULT    = 2'd2;
   localparam logic [CNT_W-1:0] TIMEOUT = 16'(MEM_TIMEOUT);

   logic [1:0]       r_state;
   logic [1:0]       w_next_state;
   logic [CNT_W-1:0] r_wait_cnt;
   logic [CNT_W-1:0] w_wait_inc;
   logic             r_mem_fault;
   logic             w_mem_stall;
   logic             w_wait_nr;
   logic             w_load_use;
   logic             w_hold_pc;
   logic             w_hold_ifid;
   logic             w_hold_idex;
   logic             w_hold_exmem;
   logic             w_flush_ifid;
   logic             w_flush_idex;

   // Hazard detection shared by the next-state and output logic
   assign w_wait_nr   = (r_state == ST_MEM_WAIT) && !MemReady;
   assign w_mem_stall = ((r_state == ST_RUN) && MemReq_MEM && !MemReady) || w_wait_nr;
   assign w_load_use  = Load_EX && (rt_EX != 5'd0) &&
                        ((rt_EX == rs_ID) || (UsesRt_ID && (rt_EX == rt_ID)));
   assign w_wait_inc  = (r_wait_cnt == {CNT_W{1'b1}}) ? r_wait_cnt : r_wait_cnt + 16'd1;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_RUN: begin
            if (MemReq_MEM && !MemReady) begin
               w_next_state = ST_MEM_WAIT;
            end
         end
         ST_MEM_WAIT: begin
            if (MemReady) begin
               w_next_state = ST_RUN;
            end else if (w_wait_inc >= TIMEOUT) begin
               w_next_state = ST_FAULT;
            end
         end
         ST_FAULT: begin
            w_next_state = ST_FAULT;
         end
         default: begin
            w_next_state = ST_RUN;
         end
      endcase
   end

   // Output logic: memory stall > branch > load-use > jump
   always_comb begin
      w_hold_pc    = 1'b0;
      w_hold_ifid  = 1'b0;
      w_hold_idex  = 1'b0;
      w_hold_exmem = 1'b0;
      w_flush_ifid = 1'b0;
      w_flush_idex = 1'b0;
      if ((r_state == ST_FAULT) || w_mem_stall) begin
         w_hold_pc    = 1'b1;
         w_hold_ifid  = 1'b1;
         w_hold_idex  = 1'b1;
         w_hold_exmem = 1'b1;
      end else if (BranchTaken_EX) begin
         w_flush_ifid = 1'b1;
         w_flush_idex = 1'b1;
      end else if (w_load_use) begin
         w_hold_pc    = 1'b1;
         w_hold_ifid  = 1'b1;
         w_flush_idex = 1'b1;
      end else if (Jump_ID) begin
         w_flush_ifid = 1'b1;
      end
   end

   // Wait counter counts consecutive not-ready cycles in MEM_WAIT and saturates
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wait_cnt <= '0;
      end else if (w_wait_nr) begin
         r_wait_cnt <= w_wait_inc;
      end else begin
         r_wait_cnt <= '0;
      end
   end

   // Sticky fault flag, cleared only by reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mem_fault <= 1'b0;
      end else if (w_next_state == ST_FAULT) begin
         r_mem_fault <= 1'b1;
      end
   end

   // Reset forces every pipeline control low, independent of state
   assign hold_PC    = !reset && w_hold_pc;
   assign hold_IFID  = !reset && w_hold_ifid;
   assign hold_IDEX  = !reset && w_hold_idex;
   assign hold_EXMEM = !reset && w_hold_exmem;
   assign flush_IFID = !reset && w_flush_ifid;
   assign flush_IDEX = !reset && w_flush_idex;
   assign ctrl_state = r_state;
   assign mem_fault  = r_mem_fault;

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] r_stall_cycles;
   logic [31:0] r_flush_events;

   // Free-running performance counters, wrapping modulo 2^32
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cycles <= '0;
         r_flush_events <= '0;
      end else begin
         if (hold_PC) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
         end
         if (flush_IFID || flush_IDEX) begin
            r_flush_events <= r_flush_events + 32'd1;
         end
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_events = r_flush_events;
`else
   assign stall_cycles = 32'd0;
   assign flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: stimulus pushes expected responses, a monitor pops and compares.
// Expected values come from a cycle-level reference model of the hazard rules.
module tb_pipe_hazard_ctrl;

   localparam int unsigned TB_TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        Load_EX;
   logic [4:0]  rt_EX;
   logic [4:0]  rs_ID;
   logic [4:0]  rt_ID;
   logic        UsesRt_ID;
   logic        BranchTaken_EX;
   logic        Jump_ID;
   logic        MemReq_MEM;
   logic        MemReady;
   logic        hold_PC;
   logic        hold_IFID;
   logic        hold_IDEX;
   logic        hold_EXMEM;
   logic        flush_IFID;
   logic        flush_IDEX;
   logic [1:0]  ctrl_state;
   logic        mem_fault;
   logic [31:0] stall_cycles;
   logic [31:0] flush_events;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(TB_TIMEOUT)) dut (
      .clk(clk), .reset(reset), .Load_EX(Load_EX), .rt_EX(rt_EX), .rs_ID(rs_ID),
      .rt_ID(rt_ID), .UsesRt_ID(UsesRt_ID), .BranchTaken_EX(BranchTaken_EX),
      .Jump_ID(Jump_ID), .MemReq_MEM(MemReq_MEM), .MemReady(MemReady),
      .hold_PC(hold_PC), .hold_IFID(hold_IFID), .hold_IDEX(hold_IDEX),
      .hold_EXMEM(hold_EXMEM), .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX),
      .ctrl_state(ctrl_state), .mem_fault(mem_fault),
      .stall_cycles(stall_cycles), .flush_events(flush_events)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  ctl;   // {hold_PC, hold_IFID, hold_IDEX, hold_EXMEM, flush_IFID, flush_IDEX}
      logic [1:0]  st;
      logic        flt;
      logic [31:0] stl;
      logic [31:0] fle;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model: architectural state after the last clock edge
   int          m_state = 0;   // 0 run, 1 waiting on memory, 2 faulted
   int          m_wait  = 0;   // consecutive not-ready cycles spent waiting
   bit          m_fault = 1'b0;
   logic [31:0] m_stall = '0;
   logic [31:0] m_flush = '0;
   int          fault_age = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
      end
   endfunction

   task automatic step(input bit rst, input bit ld, input logic [4:0] rtex,
                       input logic [4:0] rsid, input logic [4:0] rtid, input bit usesrt,
                       input bit br, input bit jmp, input bit mreq, input bit mrdy);
      exp_t e;
      bit   mstall;
      @(posedge clk);
      #1;
      reset = rst; Load_EX = ld; rt_EX = rtex; rs_ID = rsid; rt_ID = rtid;
      UsesRt_ID = usesrt; BranchTaken_EX = br; Jump_ID = jmp;
      MemReq_MEM = mreq; MemReady = mrdy;
      if (rst) begin
         m_state = 0; m_wait = 0; m_fault = 1'b0; m_stall = '0; m_flush = '0;
         e.ctl = 6'b0; e.st = 2'd0; e.flt = 1'b0; e.stl = '0; e.fle = '0;
         exp_q.push_back(e);
      end else begin
         mstall = (m_state == 0 && mreq && !mrdy) || (m_state == 1 && !mrdy);
         if (m_state == 2 || mstall)                      e.ctl = 6'b111100;
         else if (br)                                     e.ctl = 6'b000011;
         else if (ld && rtex != 0 &&
                  (rtex == rsid || (usesrt && rtex == rtid))) e.ctl = 6'b110001;
         else if (jmp)                                    e.ctl = 6'b000010;
         else                                             e.ctl = 6'b000000;
         e.st = 2'(m_state); e.flt = m_fault; e.stl = m_stall; e.fle = m_flush;
         exp_q.push_back(e);
`ifdef PIPE_PERF_CNT_EN
         if (e.ctl[5]) m_stall = m_stall + 32'd1;
         if (e.ctl[1] || e.ctl[0]) m_flush = m_flush + 32'd1;
`endif
         if (m_state == 0) begin
            if (mreq && !mrdy) m_state = 1;
         end else if (m_state == 1) begin
            if (mrdy) begin
               m_state = 0;
               m_wait  = 0;
            end else begin
               if (m_wait < 65535) m_wait++;
               if (m_wait >= TB_TIMEOUT) begin
                  m_state = 2;
                  m_fault = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic idle(input bit rst);
      step(rst, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
   endtask

   // Monitor: the DUT presents a response every cycle; compare mid-cycle
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("holds_flushes", 32'({hold_PC, hold_IFID, hold_IDEX, hold_EXMEM,
                                   flush_IFID, flush_IDEX}), 32'(e.ctl));
         chk("ctrl_state", 32'(ctrl_state), 32'(e.st));
         chk("mem_fault", 32'(mem_fault), 32'(e.flt));
         chk("stall_cycles", stall_cycles, e.stl);
         chk("flush_events", flush_events, e.fle);
      end
   end

   initial begin
      reset = 1'b1; Load_EX = 0; rt_EX = 0; rs_ID = 0; rt_ID = 0; UsesRt_ID = 0;
      BranchTaken_EX = 0; Jump_ID = 0; MemReq_MEM = 0; MemReady = 1;
      idle(1); idle(1); idle(0);

      // Load-use on rs, then the bubble clears Load_EX; rt_EX=0 never stalls
      step(0, 1, 5'd8, 5'd8, 5'd3, 0, 0, 0, 0, 1);
      idle(0);
      step(0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 1);
      step(0, 1, 5'd5, 5'd1, 5'd5, 1, 0, 0, 0, 1);
      step(0, 1, 5'd5, 5'd1, 5'd5, 0, 0, 0, 0, 1);
      // Branch over concurrent load-use, then a jump
      step(0, 1, 5'd8, 5'd8, 5'd0, 0, 1, 1, 0, 1);
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1);
      idle(0); idle(0);

      // Counter scenario: one load-use, one branch, one jump from reset
      idle(1); idle(0);
      step(0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0, 0, 1);
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 1);
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1);
      idle(0); idle(0);

      // Memory wait: ready low for 3 cycles, then high; inputs ignored while waiting
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
      step(0, 1, 5'd8, 5'd8, 5'd0, 0, 1, 1, 1, 0);
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0);
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 1);
      idle(0); idle(0);

      // Timeout into FAULT; stays faulted whatever the inputs until reset
      for (int i = 0; i < 8; i++) step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
      step(0, 1, 5'd8, 5'd8, 5'd0, 0, 1, 1, 0, 1);
      idle(0);
      idle(1); idle(0); idle(0);

      // Reset mid-wait abandons it with no residual hold
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
      step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
      idle(0); idle(0);

      // Randomized traffic with occasional resets; register numbers kept small to hit matches
      for (int i = 0; i < 3000; i++) begin
         bit rst;
         fault_age = (m_state == 2) ? fault_age + 1 : 0;
         rst = ($urandom_range(0, 149) == 0) || (fault_age > 3);
         step(rst, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 4) < 2,
              $urandom_range(0, 9) < 7);
      end

      repeat (3) @(posedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
